// File: rtl/reg_file_banked.sv
// Banked register file: three combinational read ports, two write ports,
// a shadow bank with single-cycle save/restore/swap for context switching,
// a per-register dirty mask and a registered dual-write collision flag.
module reg_file_banked #(
    parameter int DATA_W   = 16,
    parameter int ADDR_W   = 4,
    parameter int BYPASS   = 1,
    parameter int ZERO_REG = 0
) (
    input  logic                  Clock,
    input  logic                  Reset_n,
    input  logic [ADDR_W-1:0]     Rd_Addr,
    input  logic [ADDR_W-1:0]     Rs_Addr,
    input  logic [ADDR_W-1:0]     Rm_Addr,
    input  logic                  Rd_Wen,
    input  logic                  Rs_Wen,
    input  logic [DATA_W-1:0]     Rd_Data,
    input  logic [DATA_W-1:0]     Rs_Data,
    input  logic                  Save,
    input  logic                  Restore,
    output logic [DATA_W-1:0]     Rd_Out,
    output logic [DATA_W-1:0]     Rs_Out,
    output logic [DATA_W-1:0]     Rm_Out,
    output logic [2**ADDR_W-1:0]  Dirty,
    output logic                  Coll_Err
);

    localparam int   DEPTH  = 2**ADDR_W;
    localparam logic BYP_EN = (BYPASS != 0);
    localparam logic ZR_EN  = (ZERO_REG != 0);

    logic [DATA_W-1:0] main_q   [DEPTH];
    logic [DATA_W-1:0] main_d   [DEPTH];
    logic [DATA_W-1:0] shadow_q [DEPTH];
    logic [DATA_W-1:0] shadow_d [DEPTH];
    logic [DEPTH-1:0]  dirty_q;
    logic [DEPTH-1:0]  dirty_d;
    logic [DEPTH-1:0]  written_s;
    logic              coll_q;
    logic              coll_s;
    logic              wa_s;
    logic              wb_s;

    // One read port: hardwired zero first, then same-cycle bypass (A before B), then stored value.
    function automatic logic [DATA_W-1:0] read_port(
        input logic [ADDR_W-1:0] addr,
        input logic [DATA_W-1:0] stored,
        input logic              wa,
        input logic              wb,
        input logic [ADDR_W-1:0] a_addr,
        input logic [ADDR_W-1:0] b_addr,
        input logic [DATA_W-1:0] a_data,
        input logic [DATA_W-1:0] b_data
    );
        logic [DATA_W-1:0] val;
        if (ZR_EN && (addr == {ADDR_W{1'b0}})) begin
            val = {DATA_W{1'b0}};
        end else if (BYP_EN && wa && (addr == a_addr)) begin
            val = a_data;
        end else if (BYP_EN && wb && (addr == b_addr)) begin
            val = b_data;
        end else begin
            val = stored;
        end
        return val;
    endfunction

    // Effective write set: drop writes to the hardwired zero register, port A wins a collision.
    always_comb begin
        wa_s   = Rd_Wen & ~(ZR_EN & (Rd_Addr == {ADDR_W{1'b0}}));
        coll_s = wa_s & Rs_Wen & (Rd_Addr == Rs_Addr);
        wb_s   = Rs_Wen & ~(ZR_EN & (Rs_Addr == {ADDR_W{1'b0}})) & ~coll_s;
    end

    // Next-state for both banks and the dirty mask; writes land on top of a restored/swapped main.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            written_s[i] = (wa_s && (Rd_Addr == ADDR_W'(i))) ||
                           (wb_s && (Rs_Addr == ADDR_W'(i)));
            shadow_d[i]  = Save ? main_q[i] : shadow_q[i];
            main_d[i]    = (wa_s && (Rd_Addr == ADDR_W'(i))) ? Rd_Data :
                           (wb_s && (Rs_Addr == ADDR_W'(i))) ? Rs_Data :
                           (Restore ? shadow_q[i] : main_q[i]);
        end
        dirty_d = (Save || Restore) ? written_s : (dirty_q | written_s);
    end

    // Combinational read ports from the main bank.
    always_comb begin
        Rd_Out = read_port(Rd_Addr, main_q[Rd_Addr], wa_s, wb_s, Rd_Addr, Rs_Addr, Rd_Data, Rs_Data);
        Rs_Out = read_port(Rs_Addr, main_q[Rs_Addr], wa_s, wb_s, Rd_Addr, Rs_Addr, Rd_Data, Rs_Data);
        Rm_Out = read_port(Rm_Addr, main_q[Rm_Addr], wa_s, wb_s, Rd_Addr, Rs_Addr, Rd_Data, Rs_Data);
    end

    // State registers; asynchronous reset clears both banks and flags, discarding any pending copy.
    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                main_q[i]   <= {DATA_W{1'b0}};
                shadow_q[i] <= {DATA_W{1'b0}};
            end
            dirty_q <= {DEPTH{1'b0}};
            coll_q  <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                main_q[i]   <= main_d[i];
                shadow_q[i] <= shadow_d[i];
            end
            dirty_q <= dirty_d;
            coll_q  <= coll_s;
        end
    end

    assign Dirty    = dirty_q;
    assign Coll_Err = coll_q;

endmodule

// File: doc/reg_file_banked.md
Name: reg_file_banked

Overview:
Parametrised successor to the 16x16 three-read/two-write register file. Generalises data width and depth. Adds:
- defined write-collision priority with an error flag
- optional write-to-read bypass
- optional hardwired zero register
- a shadow bank with single-cycle save/restore/swap for interrupt context switching
- a per-register dirty mask

Sits in the CPU datapath between decode (addresses) and ALU/writeback (data).

Parameters:
DATA_W, 16, register width in bits
ADDR_W, 4, address width; DEPTH = 2**ADDR_W registers
BYPASS, 1, 1 = read ports forward same-cycle write data; 0 = reads return stored value only
ZERO_REG, 0, 1 = register 0 always reads 0 and ignores writes

Ports:
Clock  in  1  sole clock, rising edge
Reset_n  in  1  asynchronous active-low reset
Rd_Addr  in  ADDR_W  read port A address and write port A address
Rs_Addr  in  ADDR_W  read port B address and write port B address
Rm_Addr  in  ADDR_W  read port C address (read only)
Rd_Wen  in  1  write enable, port A
Rs_Wen  in  1  write enable, port B
Rd_Data  in  DATA_W  write data, port A
Rs_Data  in  DATA_W  write data, port B
Save  in  1  copy main bank to shadow bank
Restore  in  1  copy shadow bank to main bank
Rd_Out  out  DATA_W  read data at Rd_Addr
Rs_Out  out  DATA_W  read data at Rs_Addr
Rm_Out  out  DATA_W  read data at Rm_Addr
Dirty  out  DEPTH  bit i set = main reg i written since last Save/Restore
Coll_Err  out  1  registered pulse: previous cycle had a same-address dual write

Behaviour:
- Reset (Reset_n=0, asynchronous):
  - all main and shadow registers, Dirty and Coll_Err go to 0 immediately
  - read outputs therefore read 0
  - a reset mid-save/restore discards that operation
- Reads are combinational from the main bank, zero latency.
- Writes commit on the rising Clock edge. Effective write set:
  - A: Rd_Wen at Rd_Addr
  - B: Rs_Wen at Rs_Addr
- Collision (Rd_Wen & Rs_Wen & Rd_Addr==Rs_Addr):
  - port A data is written; port B is dropped
  - Coll_Err=1 for exactly the following cycle, else 0
- ZERO_REG=1:
  - address 0 always reads 0 on all ports, including under bypass
  - writes to address 0 are discarded, do not set Dirty[0] and do not raise Coll_Err
- BYPASS=1: a read port whose address matches an effective write in the same cycle outputs that write data, with port A winning on collision. BYPASS=0: stored value only.
- Save=1, Restore=0:
  - at the edge, shadow[i] <= main value before this cycle's writes, for all i
  - main still takes this cycle's writes
  - Dirty <= one-hot set of this cycle's effective write addresses
- Restore=1, Save=0:
  - at the edge, main[i] <= shadow[i] for all i
  - this cycle's effective writes override the restored value at their addresses
  - Dirty <= this cycle's write set
  - shadow unchanged
- Save=1 and Restore=1 (swap): main and shadow exchange contents in one edge; writes apply on top of the new main; Dirty as for Restore.
- Neither Save nor Restore: Dirty[i] <= Dirty[i] | written_i.
- No internal busy state: every operation completes in one cycle, so back-to-back Save/Restore are legal every cycle.
- Address width exactly covers DEPTH; no out-of-range case exists.
- Implementation: registers as flops (not inferred RAM), because of whole-bank copy and async reset.

Test Plan:
- Reset, then all addresses read → all ports 0, Dirty=0, Coll_Err=0. Write A: R3=0x1234 → after edge Rm_Addr=3 reads 0x1234 and Dirty=0x0008.
- Same-cycle writes R5=0xAAAA (A) and R5=0x5555 (B) → R5=0xAAAA; Coll_Err=1 for one cycle, then 0.
- BYPASS=1: Rd_Wen writes R7=0x00FF while Rm_Addr=7 → Rm_Out=0x00FF in the same cycle; with BYPASS=0 → old value 0x0000 until the edge.
- R1=0x1111; Save with a concurrent write R1=0x2222; then Restore → shadow R1=0x1111; after Restore main R1=0x1111; Dirty=0 after the Restore.
- ZERO_REG=1: write R0=0xFFFF → R0 reads 0, Dirty[0]=0. Swap with main R2=0xA, shadow R2=0xB → main R2=0xB, shadow R2=0xA.
- Assert Reset_n low between clock edges after writes → outputs drop to 0 before the next edge.
